// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, instruction register and retired-fetch counter.
// Jumps resolve in the fetch cycle; a self-loop jump halts fetch and an out-of-window PC faults.
module fetch_unit #(
    parameter int unsigned MEM_DEPTH = 32,
    parameter int unsigned COUNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    output logic [7:0]         ReadAddress,
    input  logic [7:0]         Instruction,
    input  logic               Stall,
    output logic               IrValid,
    output logic [7:0]         IrOut,
    output logic [7:0]         IrPc,
    output logic               Halted,
    output logic               Fault,
    output logic [COUNT_W-1:0] FetchCount
);

    localparam int unsigned ADDR_W = 8;
    localparam logic [1:0]  OP_JUMP = 2'd3;
    localparam logic [7:0]  SELF_LOOP = 8'hFF;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [7:0]          r_ir;
    logic [ADDR_W-1:0]   r_ir_pc;
    logic                r_ir_valid;
    logic                r_halted;
    logic                r_fault;
    logic [COUNT_W-1:0]  r_count;

    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic [7:0]          w_ir_nxt;
    logic [ADDR_W-1:0]   w_ir_pc_nxt;
    logic                w_ir_valid_nxt;
    logic                w_halted_nxt;
    logic                w_fault_nxt;
    logic [COUNT_W-1:0]  w_count_nxt;

    logic [ADDR_W-1:0]   w_pc_seq;
    logic [ADDR_W-1:0]   w_jump_off;
    logic [ADDR_W-1:0]   w_pc_target;
    logic                w_pc_oob;
    logic [COUNT_W-1:0]  w_count_inc;

    // Next-PC arithmetic wraps modulo 256; jump offset is sign-extended from 6 bits
    assign w_pc_seq    = r_pc + ADDR_W'(1);
    assign w_jump_off  = {{2{Instruction[5]}}, Instruction[5:0]};
    assign w_pc_target = (Instruction[7:6] == OP_JUMP) ? (w_pc_seq + w_jump_off) : w_pc_seq;
    assign w_pc_oob    = (32'(r_pc) >= 32'(MEM_DEPTH));
    assign w_count_inc = (&r_count) ? r_count : (r_count + COUNT_W'(1));

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_ir_nxt       = r_ir;
        w_ir_pc_nxt    = r_ir_pc;
        w_ir_valid_nxt = r_ir_valid;
        w_halted_nxt   = r_halted;
        w_fault_nxt    = r_fault;
        w_count_nxt    = r_count;

        unique case (r_state)
            FETCH: begin
                // Stall takes priority over both the fault check and the halt check
                if (!Stall) begin
                    if (w_pc_oob) begin
                        w_ir_valid_nxt = 1'b0;
                        w_fault_nxt    = 1'b1;
                        w_state_nxt    = FAULT;
                    end else begin
                        w_ir_nxt       = Instruction;
                        w_ir_pc_nxt    = r_pc;
                        w_ir_valid_nxt = 1'b1;
                        w_count_nxt    = w_count_inc;
                        if (Instruction == SELF_LOOP) begin
                            w_halted_nxt = 1'b1;
                            w_state_nxt  = HALT;
                        end else begin
                            w_pc_nxt = w_pc_target;
                        end
                    end
                end
            end
            HALT: begin
                // The halting jump stays valid until decode consumes it once
                if (!Stall) begin
                    w_ir_valid_nxt = 1'b0;
                end
            end
            FAULT: begin
                w_ir_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= FETCH;
            r_pc       <= '0;
            r_ir       <= '0;
            r_ir_pc    <= '0;
            r_ir_valid <= 1'b0;
            r_halted   <= 1'b0;
            r_fault    <= 1'b0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_ir       <= w_ir_nxt;
            r_ir_pc    <= w_ir_pc_nxt;
            r_ir_valid <= w_ir_valid_nxt;
            r_halted   <= w_halted_nxt;
            r_fault    <= w_fault_nxt;
            r_count    <= w_count_nxt;
        end
    end

    assign ReadAddress = r_pc;
    assign IrValid     = r_ir_valid;
    assign IrOut       = r_ir;
    assign IrPc        = r_ir_pc;
    assign Halted      = r_halted;
    assign Fault       = r_fault;
    assign FetchCount  = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small behavioural instruction memory and hand-computed
// expectations for straight-line fetch, stall, jumps, halt, fault and reset.
module tb_fetch_unit;

    localparam int unsigned COUNT_W = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic [7:0]         ReadAddress;
    logic [7:0]         Instruction;
    logic               Stall;
    logic               IrValid;
    logic [7:0]         IrOut;
    logic [7:0]         IrPc;
    logic               Halted;
    logic               Fault;
    logic [COUNT_W-1:0] FetchCount;

    logic [7:0] mem [256];
    int vectors = 0;
    int miscompares = 0;

    fetch_unit #(.MEM_DEPTH(32), .COUNT_W(COUNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .ReadAddress (ReadAddress),
        .Instruction (Instruction),
        .Stall       (Stall),
        .IrValid     (IrValid),
        .IrOut       (IrOut),
        .IrPc        (IrPc),
        .Halted      (Halted),
        .Fault       (Fault),
        .FetchCount  (FetchCount)
    );

    always #5 clk = ~clk;

    assign Instruction = mem[ReadAddress];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ir(input string tag, input logic [7:0] ir, input logic [7:0] pc,
                          input logic v, input logic [7:0] ra);
        chk({tag, ".IrOut"},       32'(IrOut),       32'(ir));
        chk({tag, ".IrPc"},        32'(IrPc),        32'(pc));
        chk({tag, ".IrValid"},     32'(IrValid),     32'(v));
        chk({tag, ".ReadAddress"}, 32'(ReadAddress), 32'(ra));
    endtask

    task automatic chk_reset(input string tag);
        chk_ir(tag, 8'h00, 8'h00, 1'b0, 8'h00);
        chk({tag, ".Halted"},     32'(Halted),     32'd0);
        chk({tag, ".Fault"},      32'(Fault),      32'd0);
        chk({tag, ".FetchCount"}, 32'(FetchCount), 32'd0);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    initial begin
        reset = 1'b1;
        Stall = 1'b0;
        clear_mem();
        // Program A: 0..3 straight, 3 jumps to 6, 6 jumps to 10, 10 jumps to 42 (fault)
        mem[0]  = 8'h45;
        mem[1]  = 8'h59;
        mem[2]  = 8'h1B;
        mem[3]  = 8'hC2;
        mem[6]  = 8'hC3;
        mem[10] = 8'hDF;
        tick();
        tick();
        chk_reset("reset_a");

        reset = 1'b0;
        tick();
        chk_ir("line0", 8'h45, 8'd0, 1'b1, 8'd1);
        chk("line0.FetchCount", 32'(FetchCount), 32'd1);
        tick();
        chk_ir("line1", 8'h59, 8'd1, 1'b1, 8'd2);

        Stall = 1'b1;
        tick();
        tick();
        tick();
        chk_ir("stall", 8'h59, 8'd1, 1'b1, 8'd2);
        chk("stall.FetchCount", 32'(FetchCount), 32'd2);
        Stall = 1'b0;

        tick();
        chk_ir("line2", 8'h1B, 8'd2, 1'b1, 8'd3);
        chk("line2.FetchCount", 32'(FetchCount), 32'd3);
        tick();
        chk_ir("jmp_fwd", 8'hC2, 8'd3, 1'b1, 8'd6);
        tick();
        chk_ir("jmp_tgt6", 8'hC3, 8'd6, 1'b1, 8'd10);
        tick();
        chk_ir("jmp_far", 8'hDF, 8'd10, 1'b1, 8'd42);
        chk("jmp_far.FetchCount", 32'(FetchCount), 32'd6);
        chk("jmp_far.Fault", 32'(Fault), 32'd0);
        tick();
        chk("fault.Fault", 32'(Fault), 32'd1);
        chk("fault.IrValid", 32'(IrValid), 32'd0);
        chk("fault.ReadAddress", 32'(ReadAddress), 32'd42);
        chk("fault.Halted", 32'(Halted), 32'd0);
        tick();
        chk("fault_hold.ReadAddress", 32'(ReadAddress), 32'd42);
        chk("fault_hold.FetchCount", 32'(FetchCount), 32'd6);
        chk("fault_hold.Fault", 32'(Fault), 32'd1);

        // Program B: jump 0xC0 at 5, 6->8, backward 8->7, 7->11, halt at 12
        reset = 1'b1;
        tick();
        chk_reset("reset_b");
        clear_mem();
        mem[0]  = 8'h12;
        mem[5]  = 8'hC0;
        mem[6]  = 8'hC1;
        mem[7]  = 8'hC3;
        mem[8]  = 8'hFE;
        mem[12] = 8'hFF;
        reset = 1'b0;
        tick();
        chk_ir("b_line0", 8'h12, 8'd0, 1'b1, 8'd1);
        for (int i = 1; i < 6; i++) tick();
        chk_ir("jmp_zero", 8'hC0, 8'd5, 1'b1, 8'd6);
        tick();
        chk_ir("jmp_6to8", 8'hC1, 8'd6, 1'b1, 8'd8);
        tick();
        chk_ir("jmp_back", 8'hFE, 8'd8, 1'b1, 8'd7);
        tick();
        chk_ir("jmp_7to11", 8'hC3, 8'd7, 1'b1, 8'd11);
        tick();
        chk_ir("line11", 8'h00, 8'd11, 1'b1, 8'd12);
        tick();
        chk_ir("halt_latch", 8'hFF, 8'd12, 1'b1, 8'd12);
        chk("halt_latch.Halted", 32'(Halted), 32'd1);
        chk("halt_latch.FetchCount", 32'(FetchCount), 32'd11);
        tick();
        chk_ir("halted", 8'hFF, 8'd12, 1'b0, 8'd12);
        chk("halted.Halted", 32'(Halted), 32'd1);
        chk("halted.FetchCount", 32'(FetchCount), 32'd11);

        // Reset while halted and stalled
        Stall = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        chk_reset("reset_mid");
        reset = 1'b0;
        Stall = 1'b0;
        tick();
        chk_ir("restart", 8'h12, 8'd0, 1'b1, 8'd1);
        chk("restart.FetchCount", 32'(FetchCount), 32'd1);
        chk("restart.Halted", 32'(Halted), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the 8-bit core: owns the program counter, drives the instruction memory's combinational read address, and latches the returned byte into an instruction register for the decode stage. Jumps (opcode 3) are resolved at fetch with no bubble. A self-loop jump halts fetch. A PC outside the populated memory window raises a fault.

## Interface
Parameters:
- MEM_DEPTH, 32, number of valid instruction bytes; a PC ≥ MEM_DEPTH is a fetch fault
- COUNT_W, 16, width of the retired-fetch counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, and the reset is synchronous and active-high
- ReadAddress  out  8  address to instruction memory; equals the PC register
- Instruction  in  8  memory read data, combinational from ReadAddress in the same cycle
- Stall  in  1  decode not ready; all state holds while 1
- IrValid  out  1  IrOut/IrPc hold a valid fetched instruction
- IrOut  out  8  instruction register
- IrPc  out  8  address the byte in IrOut was fetched from
- Halted  out  1  fetch stopped on self-loop jump (8'hFF)
- Fault  out  1  fetch stopped on PC ≥ MEM_DEPTH
- FetchCount  out  COUNT_W  number of instructions latched since reset

## Operation
- Encoding: [7:6] opcode (0 add, 1 load, 2 store, 3 jump); for jump, [5:0] is a signed 6-bit offset.
- Next PC:
  - jump: PC + 1 + sext(Instruction[5:0]), modulo 256.
  - otherwise: PC + 1, modulo 256 (255 wraps to 0).
- FSM states: FETCH, HALT, FAULT.
- FETCH, Stall=0, PC < MEM_DEPTH:
  - IrOut ← Instruction, IrPc ← PC, IrValid ← 1.
  - PC ← next PC.
  - FetchCount ← FetchCount + 1, saturating at all-ones.
  - If Instruction = 8'hFF (jump −1, the target is itself): still latch it, freeze PC at that address, go to HALT.
- FETCH, Stall=1: every register holds, including IrValid and IrOut. Stall beats the halt and fault checks.
- FETCH, Stall=0, PC ≥ MEM_DEPTH:
  - IrValid ← 0, nothing latched, PC held.
  - Go to FAULT.
- HALT: Halted=1. PC, IrOut and IrPc frozen. IrValid ← 0 on the first cycle with Stall=0, so the halting jump is delivered once. Leaves only on reset.
- FAULT: Fault=1, IrValid=0, PC frozen at the faulting address. Leaves only on reset.
- Reset overrides everything in any state, including mid-stall.

## Timing
- Reset values:
  - PC/ReadAddress = 0, IrOut = 0, IrPc = 0.
  - IrValid = 0, Halted = 0, Fault = 0, FetchCount = 0.
  - State = FETCH.
- First fetch is from address 0 in the first cycle after reset deasserts. IrValid rises at the end of that cycle.
- Latency: ReadAddress → IrOut is 1 clock. Sustained throughput is 1 instruction/clock, including across taken jumps.
- Handshake: decode consumes IrOut at a clock edge where IrValid=1 and Stall=0. While Stall=1, IrOut is stable and is not consumed.
- Halted and Fault assert on the clock edge that enters HALT/FAULT, and they are registered.
- ReadAddress is registered and never glitches mid-cycle.

## Test plan
- Straight line: memory 0:0x45, 1:0x59, 2:0x1B, Stall=0 → IrOut is 0x45, 0x59, 0x1B on cycles 1–3 with IrPc 0, 1, 2; FetchCount = 3.
- Forward jump: memory 3:0xC2 → after IrPc=3 the next IrPc is 6 with no gap in IrValid. Jump 0xC0 at 5 → next IrPc is 6.
- Backward jump and halt: memory 8:0xFE (offset −2) → next IrPc is 7. Memory 12:0xFF → IrOut=0xFF and IrPc=12 once, then Halted=1, IrValid=0, ReadAddress stays 12.
- Stall: assert Stall for 3 cycles while IrOut=0x59 → IrOut, IrPc, ReadAddress and FetchCount are unchanged. On release, the next byte follows with no loss or duplication.
- Fault: jump 0xDF at address 10 (offset +31) → PC becomes 42 ≥ 32, so Fault=1, IrValid=0, ReadAddress=42.
- Reset mid-operation: assert reset while in HALT with Stall=1 → next cycle all outputs are at reset values and fetch restarts at address 0.
